ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch master; sits directly upstream of the instruction-fetch memory port (AXI-lite read channel) and downstream feeds the decode stage via a valid/ready instruction interface.
- Holds the architectural fetch PC and issues one read per instruction, with at most one outstanding request.
- Redirects from execute/writeback squash any in-flight or held instruction.
- Tolerates arbitrary handshake delays on both the address and data channels.

Parameters:
RESET_PC, 32'h8000_0000, fetch PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
araddr  output  32  read address to fetch memory port
arvalid  output  1  read address valid
arready  input  1  read address ready
rdata  input  32  read data (instruction word)
rresp  input  1  read response, 1 = error
rvalid  input  1  read data valid
rready  output  1  read data ready
inst  output  32  instruction to decode
inst_pc  output  32  PC of inst
inst_fault  output  1  fetch error flag accompanying inst
inst_valid  output  1  inst/inst_pc/inst_fault valid
inst_ready  input  1  decode accepts instruction
redirect_valid  input  1  one-cycle redirect request
redirect_pc  input  32  redirect target
fetch_cnt  output  32  count of instructions accepted by decode

Behaviour:
- Reset (async): state=REQ, pc=RESET_PC, drop=0, arvalid=1 after reset release, araddr=RESET_PC, rready=0, inst_valid=0, inst/inst_pc=0, inst_fault=0, fetch_cnt=0.
- States:
  - REQ: arvalid=1, araddr=pc. On arvalid&&arready -> WAIT.
  - WAIT: rready=1, arvalid=0. On rvalid&&rready:
    - if drop: clear drop, -> REQ (pc already holds redirect target).
    - else: latch inst=rdata, inst_pc=pc, inst_fault=rresp, inst_valid=1, pc<=pc+PC_STEP, -> HOLD.
  - HOLD: inst_valid=1, outputs stable. On inst_valid&&inst_ready: inst_valid<=0, fetch_cnt+=1, -> REQ.
- AXI rules:
  - araddr stable and arvalid never deasserted while in REQ until arready.
  - rready only asserted in WAIT.
  - No second AR before R completes.
- Minimum latency: 1 cycle AR handshake + 1 cycle R; inst_valid rises the cycle after the R handshake.
- Redirect (redirect_valid=1 in a cycle):
  - REQ: pc<=redirect_pc takes effect only after the current AR handshake completes (araddr must not change while arvalid is pending). Set drop=1; the response to the old address is discarded, then REQ with redirect_pc.
  - WAIT: pc<=redirect_pc, drop=1. If rvalid arrives the same cycle, that response is discarded and the next state is REQ.
  - HOLD: held instruction is squashed, inst_valid<=0, pc<=redirect_pc, -> REQ, fetch_cnt unchanged. If inst_ready is also high that cycle, the instruction counts as accepted (fetch_cnt+=1), then REQ at redirect_pc.
  - Multiple redirects: the latest redirect_pc wins; drop stays 1 until exactly one response is discarded.
- pc arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- fetch_cnt wraps to 0 after 32'hFFFF_FFFF.
- rresp=1 does not stall: the instruction is delivered with inst_fault=1 and the PC advances normally.
- Reset mid-transaction: all state is cleared immediately; any response arriving after reset release while not in WAIT is ignored (rready=0).

Test Plan:
- Reset, memory returns 32'h0000_0013 with zero-delay handshakes, inst_ready=1 -> araddr sequence 8000_0000, 8000_0004, 8000_0008; inst_pc matches; fetch_cnt=3 after three accepts.
- Random arready/rvalid delays 0–255 cycles, inst_ready held low 10 cycles -> araddr stable while arvalid pending; inst/inst_pc stable while inst_valid&&!inst_ready; no AR issued while in HOLD.
- redirect_valid with redirect_pc=8000_0100 during WAIT at pc 8000_0008 -> returned word discarded, inst_valid stays 0, next araddr=8000_0100, first delivered inst_pc=8000_0100.
- Redirect during REQ with arready low 5 cycles -> araddr remains old value until handshake, one response dropped, next AR at redirect_pc; redirect in HOLD with inst_ready=0 -> inst_valid drops next cycle, fetch_cnt unchanged.
- rresp=1 on fetch at 8000_0004 -> inst_fault=1 with inst_pc=8000_0004; next fetch at 8000_0008 with inst_fault=0.
- Redirect to FFFF_FFFC -> next sequential araddr=0000_0000; assert rst while in WAIT -> outputs return to reset values asynchronously, fetch restarts at 8000_0000.

Source files
------------

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bundle: AXI-lite read channel toward fetch memory, valid/ready toward decode,
// redirect input from execute/writeback, and the accepted-instruction counter.
interface ifu_fetch_ctrl_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  modport master (
    output araddr, arvalid, rready, inst, inst_pc, inst_fault, inst_valid, fetch_cnt,
    input  arready, rdata, rresp, rvalid, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  araddr, arvalid, rready, inst, inst_pc, inst_fault, inst_valid, fetch_cnt,
    output arready, rdata, rresp, rvalid, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch master: one outstanding AXI-lite read per instruction, redirect squash,
// single-entry hold register toward decode.
//
// state  | meaning
// S_REQ  | AR issued at araddr_q, waiting for arready
// S_WAIT | AR accepted, rready high, waiting for the R beat
// S_HOLD | instruction presented to decode, waiting for inst_ready
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  ifu_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        drop_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_fault_q;
  logic        inst_valid_q;
  logic [31:0] fetch_cnt_q;

  logic        ar_hs;
  logic        r_hs;
  logic        dec_hs;
  logic [31:0] pc_inc_d;
  logic [31:0] fetch_cnt_d;
  logic [31:0] redir_pc_d;

  assign ar_hs       = arvalid_q & bus.arready;
  assign r_hs        = rready_q & bus.rvalid;
  assign dec_hs      = inst_valid_q & bus.inst_ready;
  assign pc_inc_d    = pc_q + PC_STEP;
  assign fetch_cnt_d = fetch_cnt_q + 32'd1;
  // A same-cycle redirect beats whatever target pc_q already holds.
  assign redir_pc_d  = bus.redirect_valid ? bus.redirect_pc : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      araddr_q     <= RESET_PC;
      arvalid_q    <= 1'b1;
      rready_q     <= 1'b0;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
      inst_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          // araddr_q is frozen while arvalid pends; only the architectural pc moves.
          if (bus.redirect_valid) begin
            pc_q   <= bus.redirect_pc;
            drop_q <= 1'b1;
          end
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            if (drop_q || bus.redirect_valid) begin
              drop_q    <= 1'b0;
              pc_q      <= redir_pc_d;
              araddr_q  <= redir_pc_d;
              arvalid_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              inst_q       <= bus.rdata;
              inst_pc_q    <= pc_q;
              inst_fault_q <= bus.rresp;
              inst_valid_q <= 1'b1;
              pc_q         <= pc_inc_d;
              state_q      <= S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            pc_q   <= bus.redirect_pc;
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (dec_hs) begin
            fetch_cnt_q <= fetch_cnt_d;
          end
          if (dec_hs || bus.redirect_valid) begin
            inst_valid_q <= 1'b0;
            pc_q         <= redir_pc_d;
            araddr_q     <= redir_pc_d;
            arvalid_q    <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        default: begin
          state_q   <= S_REQ;
          araddr_q  <= pc_q;
          arvalid_q <= 1'b1;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.araddr     = araddr_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_fault = inst_fault_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fetch_cnt  = fetch_cnt_q;

endmodule
